// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, one-hot
// T-states and the bit layout of the 12-bit control word.
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int RING_LEN = 6;
    localparam int CW_W     = 12;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [RING_LEN-1:0] T1 = 6'b000001;
    localparam logic [RING_LEN-1:0] T2 = 6'b000010;
    localparam logic [RING_LEN-1:0] T3 = 6'b000100;
    localparam logic [RING_LEN-1:0] T4 = 6'b001000;
    localparam logic [RING_LEN-1:0] T5 = 6'b010000;
    localparam logic [RING_LEN-1:0] T6 = 6'b100000;

    // Control word bit positions, MSB first: cp ep n_lm n_ce n_li n_ei n_la ea su eu n_lb n_lo
    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_N_LM = 9;
    localparam int CW_N_CE = 8;
    localparam int CW_N_LI = 7;
    localparam int CW_N_EI = 6;
    localparam int CW_N_LA = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_N_LB = 1;
    localparam int CW_N_LO = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Every active-high strobe low, every active-low strobe high.
    localparam ctrl_word_t CW_INACTIVE = 12'b0011_1110_0011;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter: rotates left each clock unless held,
// synchronous reset to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    output logic [RING_LEN-1:0] t_state
);

    logic [RING_LEN-1:0] t_next;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        t_next = t_state;
        if (!hold) begin
            t_next = {t_state[RING_LEN-2:0], t_state[RING_LEN-1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= T1;
        end else begin
            t_state <= t_next;
        end
    end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: ring counter plus halt flag, with the T-state/opcode
// decode that produces the 12-bit control word for the datapath.
module sap1_controller_sequencer
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                cp,
    output logic                ep,
    output logic                n_lm,
    output logic                n_ce,
    output logic                n_li,
    output logic                n_ei,
    output logic                n_la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                n_lb,
    output logic                n_lo,
    output logic [RING_LEN-1:0] t_state,
    output logic                halted
);

    ctrl_word_t cw;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .hold    (halted),
        .t_state (t_state)
    );

    // The ring leaves T4 on the same edge that sets halted, so it freezes at T5.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (t_state == T4 && opcode == OP_HLT) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw = CW_INACTIVE;
        if (!halted) begin
            case (t_state)
                T1: begin
                    cw[CW_EP]   = 1'b1;
                    cw[CW_N_LM] = 1'b0;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_N_CE] = 1'b0;
                    cw[CW_N_LI] = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_N_EI] = 1'b0;
                            cw[CW_N_LM] = 1'b0;
                        end
                        OP_OUT: begin
                            cw[CW_EA]   = 1'b1;
                            cw[CW_N_LO] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            cw[CW_N_CE] = 1'b0;
                            cw[CW_N_LA] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_N_CE] = 1'b0;
                            cw[CW_N_LB] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw[CW_EU]   = 1'b1;
                        cw[CW_N_LA] = 1'b0;
                        cw[CW_SU]   = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cp   = cw[CW_CP];
    assign ep   = cw[CW_EP];
    assign n_lm = cw[CW_N_LM];
    assign n_ce = cw[CW_N_CE];
    assign n_li = cw[CW_N_LI];
    assign n_ei = cw[CW_N_EI];
    assign n_la = cw[CW_N_LA];
    assign ea   = cw[CW_EA];
    assign su   = cw[CW_SU];
    assign eu   = cw[CW_EU];
    assign n_lb = cw[CW_N_LB];
    assign n_lo = cw[CW_N_LO];

endmodule
